hazard3_trigger_prog_seq: RTL and testbench
===========================================

// Module: hazard3_trigger_prog_seq
// PURPOSE
//  Owns the trigger unit's cfg port (cfg_addr/cfg_wen/cfg_wdata/cfg_rdata) and shares it between two requesters:
//  - the CSR-instruction path, passed straight through;
//  - a debug-side programming engine, served by an atomic multi-cycle sequence.
//  The sequence saves tselect, disables the trigger, writes tdata2 then tdata1, optionally reads tdata1 back,
//  and restores tselect. Instantiated in core between the CSR block and the trigger unit.
// PARAMETERS
//  N_TRIG        2  number of breakpoint triggers; W_IDX = max(1, $clog2(N_TRIG))
//  PROG_MAX_WAIT 4  IDLE cycles a waiting prog request may lose to csr_req before it pre-empts; must be >=1
// PORTS
//  clk         in   1   clock
//  rst         in   1   asynchronous reset, active-high
//  csr_req     in   1   CSR-path access to 0x7a0 TSELECT, 0x7a1 TDATA1 or 0x7a2 TDATA2
//  csr_addr    in   12  CSR address
//  csr_wen     in   1   CSR write
//  csr_wdata   in   32  CSR write data
//  csr_rdata   out  32  cfg_rdata in pass-through, else 0
//  csr_stall   out  1   CSR access not performed this cycle; requester must hold it
//  prog_valid  in   1   program request; fields held stable until prog_ready
//  prog_ready  out  1   request accepted this cycle
//  prog_index  in   W_IDX  trigger to program
//  prog_tdata1 in   32  final tdata1 value
//  prog_tdata2 in   32  tdata2 value (match address)
//  prog_done   out  1   one-cycle pulse, sequence complete
//  prog_err    out  1   readback mismatch; valid only while prog_done=1
//  cfg_addr    out  12  to trigger unit
//  cfg_wen     out  1   to trigger unit
//  cfg_wdata   out  32  to trigger unit
//  cfg_rdata   in   32  from trigger unit, combinational on cfg_addr
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0, saved_tsel=0.
//   Outputs: prog_ready=0, prog_done=0, prog_err=0, csr_stall=0, cfg_wen=0, cfg_addr=0, cfg_wdata=0.
//  States: IDLE -> SAVE -> SEL -> DIS -> T2 -> T1 -> [RB] -> RESTORE -> IDLE, one cycle each, no back-pressure.
//  IDLE, no accept:
//   - CSR pass-through with zero latency: cfg_addr=csr_addr, cfg_wen=csr_req&csr_wen, cfg_wdata=csr_wdata.
//   - csr_stall=0.
//  IDLE accept condition:
//   - prog_ready = prog_valid & (!csr_req | wait_cnt==PROG_MAX_WAIT).
//   - On accept: latch index/tdata1/tdata2; go to SAVE.
//   - cfg_wen=0; csr_stall=csr_req, so a pre-empted CSR access is stalled, never dropped.
//  wait_cnt:
//   - +1 per IDLE cycle with prog_valid & csr_req & !prog_ready, saturating at PROG_MAX_WAIT.
//   - Cleared on accept or when prog_valid=0.
//  csr_stall=1 in every non-IDLE state. csr_rdata=0 whenever csr_stall=1.
//  Per-state cfg port drive (reads use cfg_wen=0):
//   - SAVE: read 0x7a0; saved_tsel <= cfg_rdata[W_IDX-1:0].
//   - SEL: write 0x7a0 = index, zero-extended.
//   - DIS: write 0x7a1 = 0. Disables execute before the address changes, so no spurious match on a stale half-written pair.
//   - T2: write 0x7a2 = tdata2.
//   - T1: write 0x7a1 = tdata1.
//   - RB: read 0x7a1; prog_err <= ((cfg_rdata ^ tdata1) & 32'h0800_104c) != 0.
//     The mask covers writable bits dmode, action, m, u and execute.
//   - RESTORE: write 0x7a0 = saved_tsel; prog_done=1.
//  Latency: accept at cycle 0 -> prog_done at cycle 7. Next accept no earlier than the cycle after RESTORE.
//  Out-of-range index, or a dmode trigger written outside D-mode:
//   - The trigger unit silently drops the writes; the sequence still completes.
//   - Mismatch is reported only via prog_err.
//  Reset mid-sequence: immediate return to IDLE with reset outputs; no prog_done.
//   tselect and trigger state are whatever the trigger unit holds, since it shares the reset.
// CONFIGURATION
//  HAZARD3_TRIGGER_PROG_VERIFY_EN:
//   - Defined: RB state present, prog_err as above, latency 7.
//   - Undefined: RB omitted (T1 -> RESTORE), prog_err tied 0, no readback of 0x7a1, latency 6.
// TESTING
//  1 IDLE, csr_req=1 wen=1 addr=0x7a2 wdata=0x1234 -> same cycle cfg_wen=1 cfg_addr=0x7a2 cfg_wdata=0x1234, csr_stall=0.
//  2 tselect=1; prog idx=0 tdata2=0x400 tdata1=0x2000_004c
//    -> cfg ops in order: rd 7a0; wr 7a0=0; wr 7a1=0; wr 7a2=0x400; wr 7a1=0x2000_004c; rd 7a1; wr 7a0=1.
//    -> prog_done at cycle 7, prog_err=0; trigger 0 then reads tdata2=0x400.
//  3 csr_req held high with prog_valid=1 -> prog_ready in 5th cycle (wait_cnt=4).
//    -> csr_stall high 8 consecutive cycles; held CSR access performed the cycle after RESTORE.
//  4 N_TRIG=2, prog idx=1... idx=3 (out of range, W_IDX forces 1 bit so use N_TRIG=3, idx=3) tdata1=0x44 -> readback 0, prog_err=1 with prog_done.
//  5 rst pulsed during T2 -> next cycle state IDLE, all outputs 0, no prog_done; new request then completes normally.
//  6 Macro undefined, repeat test 2 -> no 7a1 read, prog_done at cycle 6, prog_err=0.

Source files
------------

// File: rtl/hazard3_trigger_prog_seq.sv
// Arbitrates the trigger cfg port between CSR accesses and an atomic trigger programming sequence.
// Define HAZARD3_TRIGGER_PROG_VERIFY_EN to add the tdata1 readback check (RB state, prog_err).
module hazard3_trigger_prog_seq #(
    parameter int N_TRIG        = 2,
    parameter int PROG_MAX_WAIT = 4,
    localparam int W_IDX        = (N_TRIG > 1) ? $clog2(N_TRIG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_req,
    input  logic [11:0]      csr_addr,
    input  logic             csr_wen,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    output logic             csr_stall,
    input  logic             prog_valid,
    output logic             prog_ready,
    input  logic [W_IDX-1:0] prog_index,
    input  logic [31:0]      prog_tdata1,
    input  logic [31:0]      prog_tdata2,
    output logic             prog_done,
    output logic             prog_err,
    output logic [11:0]      cfg_addr,
    output logic             cfg_wen,
    output logic [31:0]      cfg_wdata,
    input  logic [31:0]      cfg_rdata
);

    localparam int WW = $clog2(PROG_MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_W = WW'(PROG_MAX_WAIT);
    localparam logic [11:0] A_TSEL = 12'h7a0;
    localparam logic [11:0] A_TD1  = 12'h7a1;
    localparam logic [11:0] A_TD2  = 12'h7a2;

    typedef enum logic [2:0] {
        S_IDLE, S_SAVE, S_SEL, S_DIS, S_T2, S_T1, S_RB, S_RESTORE
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [W_IDX-1:0]  idx_q, idx_d;
    logic [W_IDX-1:0]  tsel_q, tsel_d;
    logic [31:0]       td1_q, td1_d;
    logic [31:0]       td2_q, td2_d;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
    localparam logic [31:0] RB_MASK = 32'h0800_104c;
    logic              err_q, err_d;
`endif

    assign prog_ready = (state_q == S_IDLE) & prog_valid
                      & (~csr_req | (wait_q == MAX_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            tsel_q  <= '0;
            td1_q   <= '0;
            td2_q   <= '0;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            tsel_q  <= tsel_d;
            td1_q   <= td1_d;
            td2_q   <= td2_d;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        tsel_d  = tsel_q;
        td1_d   = td1_q;
        td2_d   = td2_q;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (prog_ready) begin
                    state_d = S_SAVE;
                    wait_d  = '0;
                    idx_d   = prog_index;
                    td1_d   = prog_tdata1;
                    td2_d   = prog_tdata2;
                end else if (prog_valid && csr_req) begin
                    if (wait_q != MAX_W) wait_d = wait_q + 1'b1;
                end else begin
                    wait_d = '0;
                end
            end
            S_SAVE: begin
                tsel_d  = cfg_rdata[W_IDX-1:0];
                state_d = S_SEL;
            end
            S_SEL: state_d = S_DIS;
            S_DIS: state_d = S_T2;
            S_T2:  state_d = S_T1;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
            S_T1:  state_d = S_RB;
            S_RB: begin
                err_d   = |((cfg_rdata ^ td1_q) & RB_MASK);
                state_d = S_RESTORE;
            end
`else
            S_T1:  state_d = S_RESTORE;
`endif
            S_RESTORE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_addr  = 12'h000;
        cfg_wen   = 1'b0;
        cfg_wdata = 32'h0;
        csr_stall = 1'b1;
        prog_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cfg_addr  = csr_addr;
                cfg_wdata = csr_wdata;
                cfg_wen   = csr_req & csr_wen & ~prog_ready;
                csr_stall = csr_req & prog_ready;
            end
            S_SAVE: cfg_addr = A_TSEL;
            S_SEL: begin
                cfg_addr  = A_TSEL;
                cfg_wen   = 1'b1;
                cfg_wdata = 32'(idx_q);
            end
            // Clear execute before touching tdata2 so a stale pair never matches.
            S_DIS: begin
                cfg_addr = A_TD1;
                cfg_wen  = 1'b1;
            end
            S_T2: begin
                cfg_addr  = A_TD2;
                cfg_wen   = 1'b1;
                cfg_wdata = td2_q;
            end
            S_T1: begin
                cfg_addr  = A_TD1;
                cfg_wen   = 1'b1;
                cfg_wdata = td1_q;
            end
            S_RB: cfg_addr = A_TD1;
            S_RESTORE: begin
                cfg_addr  = A_TSEL;
                cfg_wen   = 1'b1;
                cfg_wdata = 32'(tsel_q);
                prog_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign csr_rdata = csr_stall ? 32'h0 : cfg_rdata;

`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
    assign prog_err = prog_done & err_q;
`else
    assign prog_err = 1'b0;
`endif

endmodule

// File: tb/tb_hazard3_trigger_prog_seq.sv
// Bench for hazard3_trigger_prog_seq: trigger unit model, expected cfg ops queued per request.
// Built with or without HAZARD3_TRIGGER_PROG_VERIFY_EN, matching the DUT build.
module tb_hazard3_trigger_prog_seq;

    localparam int N_TRIG = 3;
    localparam int MAXW   = 4;
    localparam int W_IDX  = 2;
    localparam logic [31:0] MASK = 32'h0800_104c;
`ifdef HAZARD3_TRIGGER_PROG_VERIFY_EN
    localparam int NOPS   = 7;
    localparam bit VERIFY = 1'b1;
`else
    localparam int NOPS   = 6;
    localparam bit VERIFY = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             csr_req;
    logic [11:0]      csr_addr;
    logic             csr_wen;
    logic [31:0]      csr_wdata;
    logic [31:0]      csr_rdata;
    logic             csr_stall;
    logic             prog_valid;
    logic             prog_ready;
    logic [W_IDX-1:0] prog_index;
    logic [31:0]      prog_tdata1;
    logic [31:0]      prog_tdata2;
    logic             prog_done;
    logic             prog_err;
    logic [11:0]      cfg_addr;
    logic             cfg_wen;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;

    int total = 0;
    int bad   = 0;

    hazard3_trigger_prog_seq #(
        .N_TRIG(N_TRIG),
        .PROG_MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_req(csr_req), .csr_addr(csr_addr), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_stall(csr_stall),
        .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_index(prog_index), .prog_tdata1(prog_tdata1),
        .prog_tdata2(prog_tdata2), .prog_done(prog_done), .prog_err(prog_err),
        .cfg_addr(cfg_addr), .cfg_wen(cfg_wen), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trigger unit: out-of-range tselect and dmode writes are dropped
    logic [W_IDX-1:0] env_tsel;
    logic [31:0]      env_t1 [N_TRIG];
    logic [31:0]      env_t2 [N_TRIG];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            env_tsel <= '0;
            for (int i = 0; i < N_TRIG; i++) begin
                env_t1[i] <= '0;
                env_t2[i] <= '0;
            end
        end else if (cfg_wen) begin
            case (cfg_addr)
                12'h7a0: env_tsel <= cfg_wdata[W_IDX-1:0];
                12'h7a1: if (int'(env_tsel) < N_TRIG && !cfg_wdata[27])
                    env_t1[env_tsel] <= cfg_wdata;
                12'h7a2: if (int'(env_tsel) < N_TRIG)
                    env_t2[env_tsel] <= cfg_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = 32'h0;
        case (cfg_addr)
            12'h7a0: cfg_rdata = 32'(env_tsel);
            12'h7a1: if (int'(env_tsel) < N_TRIG) cfg_rdata = env_t1[env_tsel];
            12'h7a2: if (int'(env_tsel) < N_TRIG) cfg_rdata = env_t2[env_tsel];
            default: ;
        endcase
    end

    typedef struct packed {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] data;
        logic        err;
    } op_t;

    op_t expq[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected cfg traffic for one programming request
    function automatic void push_seq(logic [1:0] idx, logic [31:0] td1, logic [31:0] td2);
        logic [31:0] rb;
        logic        err;
        rb  = (int'(idx) >= N_TRIG || td1[27]) ? 32'h0 : td1;
        err = VERIFY && (((rb ^ td1) & MASK) != 0);
        expq.push_back('{1'b0, 12'h7a0, 32'h0, 1'b0});
        expq.push_back('{1'b1, 12'h7a0, 32'(idx), 1'b0});
        expq.push_back('{1'b1, 12'h7a1, 32'h0, 1'b0});
        expq.push_back('{1'b1, 12'h7a2, td2, 1'b0});
        expq.push_back('{1'b1, 12'h7a1, td1, 1'b0});
        if (VERIFY) expq.push_back('{1'b0, 12'h7a1, 32'h0, 1'b0});
        expq.push_back('{1'b1, 12'h7a0, 32'(env_tsel), err});
    endfunction

    int seq_left = 0;
    int waited   = 0;

    always @(negedge clk) begin
        op_t e;
        bit  exp_ready;
        if (rst) begin
            expq.delete();
            seq_left = 0;
            waited   = 0;
            chk("rst_ctl", {27'd0, prog_ready, prog_done, prog_err, csr_stall, cfg_wen}, 32'h0);
            chk("rst_addr", {20'd0, cfg_addr}, 32'h0);
            chk("rst_wdata", cfg_wdata, 32'h0);
        end else if (seq_left > 0) begin
            e = '0;
            if (expq.size() == 0) chk("queue_empty", 32'd1, 32'd0);
            else e = expq.pop_front();
            chk("op_wen", {31'd0, cfg_wen}, {31'd0, e.wen});
            chk("op_addr", {20'd0, cfg_addr}, {20'd0, e.addr});
            if (e.wen) chk("op_wdata", cfg_wdata, e.data);
            chk("seq_stall", {31'd0, csr_stall}, 32'd1);
            chk("seq_rdata", csr_rdata, 32'h0);
            chk("seq_done", {31'd0, prog_done}, {31'd0, seq_left == 1});
            if (seq_left == 1) chk("seq_err", {31'd0, prog_err}, {31'd0, e.err});
            seq_left--;
        end else begin
            chk("idle_done", {31'd0, prog_done}, 32'd0);
            exp_ready = prog_valid && (!csr_req || waited == MAXW);
            chk("ready", {31'd0, prog_ready}, {31'd0, exp_ready});
            if (exp_ready) begin
                chk("acc_wen", {31'd0, cfg_wen}, 32'd0);
                chk("acc_stall", {31'd0, csr_stall}, {31'd0, csr_req});
                seq_left = NOPS;
                waited   = 0;
            end else begin
                chk("pt_wen", {31'd0, cfg_wen}, {31'd0, csr_req & csr_wen});
                chk("pt_addr", {20'd0, cfg_addr}, {20'd0, csr_addr});
                chk("pt_wdata", cfg_wdata, csr_wdata);
                chk("pt_stall", {31'd0, csr_stall}, 32'd0);
                chk("pt_rdata", csr_rdata, cfg_rdata);
                if (prog_valid && csr_req) waited = (waited < MAXW) ? waited + 1 : MAXW;
                else waited = 0;
            end
        end
    end

    task automatic csr_op(input logic [11:0] a, input bit w, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        csr_req = 1'b1; csr_addr = a; csr_wen = w; csr_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = !csr_stall;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("csr_timeout", 32'd0, 32'd1);
        csr_req = 1'b0; csr_addr = '0; csr_wen = 1'b0; csr_wdata = '0;
    endtask

    task automatic prog_op(input logic [1:0] idx, input logic [31:0] td1,
                           input logic [31:0] td2, output int cyc);
        bit acc;
        acc = 1'b0;
        cyc = 0;
        push_seq(idx, td1, td2);
        prog_valid = 1'b1; prog_index = idx; prog_tdata1 = td1; prog_tdata2 = td2;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = prog_ready;
            cyc++;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("prog_timeout", 32'd0, 32'd1);
        prog_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            got = prog_done;
            @(posedge clk);
            #1;
        end
        chk("latency", n, got ? NOPS : -1);
    endtask

    task automatic csr_stream(input int n);
        for (int k = 0; k < n; k++)
            csr_op(($urandom_range(0, 1) != 0) ? 12'h7a1 : 12'h7a2,
                   $urandom_range(0, 1) != 0, $urandom);
    endtask

    initial begin
        int cyc;
        int r;
        rst = 1'b1;
        csr_req = 1'b0; csr_addr = '0; csr_wen = 1'b0; csr_wdata = '0;
        prog_valid = 1'b0; prog_index = '0; prog_tdata1 = '0; prog_tdata2 = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        csr_op(12'h7a2, 1'b1, 32'h1234);

        csr_op(12'h7a0, 1'b1, 32'h1);
        prog_op(2'd0, 32'h2000_004c, 32'h400, cyc);
        chk("t2_first_try", cyc, 1);
        wait_done();
        chk("tsel_restored", 32'(env_tsel), 32'h1);
        chk("t2_written", env_t2[0], 32'h400);

        fork
            csr_stream(12);
            begin
                prog_op(2'd1, 32'h0000_0044, 32'h8000, cyc);
                chk("preempt_cycle", cyc, MAXW + 1);
                wait_done();
            end
        join

        prog_op(2'd3, 32'h0000_0044, 32'h800, cyc);
        wait_done();
        prog_op(2'd2, 32'h0800_0044, 32'h900, cyc);
        wait_done();
        chk("t1_dmode_drop", env_t1[2], 32'h0);

        prog_op(2'd1, 32'h0000_004c, 32'hbeef, cyc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tsel", 32'(env_tsel), 32'h0);
        @(posedge clk);
        #1;
        prog_op(2'd1, 32'h0000_004c, 32'hbeef, cyc);
        wait_done();
        chk("t2_after_rst", env_t2[1], 32'hbeef);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: csr_op(12'h7a0 + 12'($urandom_range(0, 2)),
                          $urandom_range(0, 1) != 0, $urandom);
                1: begin
                    prog_op(2'($urandom_range(0, 3)), $urandom, $urandom, cyc);
                    wait_done();
                end
                2: fork
                    csr_stream($urandom_range(1, 8));
                    begin
                        prog_op(2'($urandom_range(0, 3)), $urandom, $urandom, cyc);
                        wait_done();
                    end
                join
                default: repeat ($urandom_range(1, 3)) @(posedge clk);
            endcase
            #1;
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
